// File: rtl/xs3_pkg.sv
// Shared constants and FSM state type for the Excess-3 receive path.
package xs3_pkg;

    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;
    localparam logic [3:0] BCD_BAD    = 4'hF;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/xs3_digit_dec.sv
// Single-digit Excess-3 to BCD decoder; out-of-range codes map to BCD_BAD.
module xs3_digit_dec
    import xs3_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [3:0] bcd_o,
    output logic       bad_o
);

    always_comb begin
        bad_o = (code_i < XS3_MIN) || (code_i > XS3_MAX);
        bcd_o = bad_o ? BCD_BAD : (code_i - XS3_OFFSET);
    end

endmodule

// File: rtl/xs3_to_bcd_deser.sv
// Collects NDIG Excess-3 digits (MSD first) into one packed BCD word with a
// per-nibble error mask, presented on a valid/ready output port.
module xs3_to_bcd_deser
    import xs3_pkg::*;
#(
    parameter int unsigned NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_digit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] out_bcd,
    output logic [NDIG-1:0]   out_err_mask,
    output logic              out_err
);

    localparam int unsigned     CW       = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(NDIG - 1);

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [4*NDIG-1:0]   bcd_sr_q, bcd_sr_d;
    logic [NDIG-1:0]     mask_sr_q, mask_sr_d;
    logic [4*NDIG-1:0]   out_bcd_q;
    logic [NDIG-1:0]     out_mask_q;
    logic                out_valid_q;
    logic [3:0]          nib;
    logic                bad;
    logic                acc;

    xs3_digit_dec u_dec (
        .code_i (in_digit),
        .bcd_o  (nib),
        .bad_o  (bad)
    );

    if (NDIG == 1) begin : g_one
        assign bcd_sr_d  = nib;
        assign mask_sr_d = bad;
    end else begin : g_multi
        assign bcd_sr_d  = {bcd_sr_q[4*NDIG-5:0], nib};
        assign mask_sr_d = {mask_sr_q[NDIG-2:0], bad};
    end

    // While a word is held, a new digit may enter only in the cycle the word leaves.
    assign in_ready = !rst && ((state_q == COLLECT) || out_ready);
    assign acc      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            bcd_sr_q    <= '0;
            mask_sr_q   <= '0;
            out_bcd_q   <= '0;
            out_mask_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (acc) begin
                bcd_sr_q  <= bcd_sr_d;
                mask_sr_q <= mask_sr_d;
            end
            case (state_q)
                COLLECT: begin
                    if (acc) begin
                        if (cnt_q == CNT_LAST) begin
                            out_bcd_q   <= bcd_sr_d;
                            out_mask_q  <= mask_sr_d;
                            out_valid_q <= 1'b1;
                            state_q     <= HOLD;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        if (acc && (NDIG == 1)) begin
                            out_bcd_q  <= bcd_sr_d;
                            out_mask_q <= mask_sr_d;
                        end else begin
                            out_valid_q <= 1'b0;
                            state_q     <= COLLECT;
                            cnt_q       <= acc ? CW'(1) : '0;
                        end
                    end
                end
                default: begin
                    state_q     <= COLLECT;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_bcd      = out_bcd_q;
    assign out_err_mask = out_mask_q;
    assign out_err      = |out_mask_q;

endmodule
